// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared address-map constants and the external bridge state encoding.
package mem_map_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [31:0] INT_RAM_BASE  = 32'h0000_0A00;
    localparam logic [31:0] INT_RAM_SIZE  = 32'h0000_0400;
    localparam logic [31:0] BUS_ERR_RDATA = 32'h0;
endpackage

// File: rtl/ext_mem_bridge_if.sv
// ext_mem_bridge_if: CPU-side and external-memory-side signals of the bridge.
interface ext_mem_bridge_if;
    logic        cs;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        bus_err;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    modport slave (
        input  cs, cpu_addr, cpu_wdata, cpu_re, cpu_we, ext_rdata, ext_ack,
        output cpu_rdata, cpu_stall, cpu_done, bus_err, ext_req, ext_we, ext_addr, ext_wdata
    );
    modport master (
        output cs, cpu_addr, cpu_wdata, cpu_re, cpu_we, ext_rdata, ext_ack,
        input  cpu_rdata, cpu_stall, cpu_done, bus_err, ext_req, ext_we, ext_addr, ext_wdata
    );
endinterface

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: req/ack responder for external data accesses, stalling the CPU
// until the external memory acknowledges or the wait counter times out.
module ext_mem_bridge
    import mem_map_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst_n,
    ext_mem_bridge_if.slave bus
);
    if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
        $error("ext_mem_bridge: TIMEOUT must be in 1..2^CNT_W-1");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             start, ack_hit, tmo_hit;

    assign start   = bus.cs & (bus.cpu_re | bus.cpu_we);
    assign ack_hit = (state == REQ) & bus.ext_ack;
    assign tmo_hit = (state == REQ) & ~bus.ext_ack & (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? REQ : IDLE) :
                   (state == REQ)  ? ((ack_hit | tmo_hit) ? DONE : REQ) : IDLE;
    end

    // Stall is released while reset is held so a frozen pipeline cannot outlive it.
    assign bus.cpu_stall = rst_n & (((state == IDLE) & start) | (state == REQ));
    assign bus.cpu_done  = (state == DONE);
    assign bus.bus_err   = (state == DONE) & err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            err           <= 1'b0;
            bus.ext_req   <= 1'b0;
            bus.ext_we    <= 1'b0;
            bus.ext_addr  <= '0;
            bus.ext_wdata <= '0;
            bus.cpu_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                bus.ext_addr  <= bus.cpu_addr;
                bus.ext_wdata <= bus.cpu_wdata;
                bus.ext_we    <= bus.cpu_we;
                bus.ext_req   <= 1'b1;
                cnt           <= '0;
                err           <= 1'b0;
            end
            if (ack_hit) begin
                bus.ext_req <= 1'b0;
                if (!bus.ext_we) bus.cpu_rdata <= bus.ext_rdata;
            end else if (tmo_hit) begin
                bus.ext_req   <= 1'b0;
                bus.cpu_rdata <= BUS_ERR_RDATA;
                err           <= 1'b1;
            end else if (state == REQ && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
- Responder for the external half of the address map: services every CPU data access where cs=1 (addresses outside internal RAM 0x0A00–0x0DFF).
- Runs a req/ack handshake with a slow external memory.
- Stalls the CPU until the access completes or times out.
- Sits beside the internal DataMemory, on the opposite side of the address decoder.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for ext_ack before aborting; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  decoder output; 1 = external access
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_re  in  1  load request
- cpu_we  in  1  store request
- cpu_rdata  out  32  load data, valid while cpu_done=1
- cpu_stall  out  1  freeze pipeline
- cpu_done  out  1  one-cycle completion strobe
- bus_err  out  1  one-cycle timeout strobe, coincident with cpu_done
- ext_req  out  1  external request, registered
- ext_we  out  1  1 = write, registered
- ext_addr  out  32  registered
- ext_wdata  out  32  registered
- ext_rdata  in  32  external read data, sampled on ext_ack
- ext_ack  in  1  external acknowledge, single-cycle pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - ext_req, ext_we, cpu_done, bus_err = 0.
  - ext_addr, ext_wdata, cpu_rdata = 0.
  - An in-flight access is abandoned; ext_req drops immediately.
- start = cs & (cpu_re | cpu_we), evaluated only in IDLE.
- cpu_stall (combinational) = (state==IDLE & start) | (state==REQ). It rises in the same cycle the access is presented.
- IDLE:
  - On start, latch cpu_addr, cpu_wdata and ext_we=cpu_we. If cpu_re and cpu_we are both high, write wins.
  - Set ext_req=1, counter=0, go to REQ. ext_req is first visible the cycle after start.
- REQ:
  - ext_req is held at 1; addr, data and we are stable.
  - If ext_ack=1: drop ext_req. Latch cpu_rdata = ext_wdata-independent ext_rdata on reads; cpu_rdata is unchanged on writes. Go to DONE.
  - Else if counter==TIMEOUT-1: drop ext_req, cpu_rdata=0, set bus_err flag, go to DONE.
  - Else counter++.
  - If ack and timeout land in the same cycle, ack wins and there is no error.
- DONE (exactly 1 cycle):
  - cpu_done=1, cpu_stall=0, bus_err=1 only if the access timed out.
  - The CPU completes the held instruction at the end of this cycle.
  - start is ignored in DONE; next state is always IDLE.
- Latency: access presented at cycle 0, ext_req high at cycle 1, ack at cycle k≥1 → cpu_done at cycle k+1. Zero-wait external memory (ack at cycle 1) gives a total stall of 2 cycles.
- ext_ack outside REQ is ignored, with no state change.
- cs=0 accesses never touch any output; stall stays 0.
- Counter saturates and never wraps. TIMEOUT must be ≤ 2^CNT_W-1; an elaboration check enforces this.

Decomposition:
- Shared package (mem_map_pkg):
  - state enum {IDLE, REQ, DONE}.
  - Internal RAM base 0x0A00 and size 0x400.
  - BUS_ERR_RDATA=32'h0.
- No sub-module: one FSM plus counter plus holding registers. The decoder stays a separate existing block driving cs.

Test Plan:
- Read, ack on 3rd REQ cycle:
  - Stimulus: cs=1, cpu_re=1, addr=0x1000; ext_rdata=0xCAFEF00D with ack at cycle 3.
  - Response: ext_req high cycles 1–3, ext_addr=0x1000, ext_we=0; cpu_done at cycle 4 with cpu_rdata=0xCAFEF00D; stall high cycles 0–3.
- Write, zero-wait:
  - Stimulus: cs=1, cpu_we=1, addr=0x2000, wdata=0x12345678; ack at cycle 1.
  - Response: ext_we=1, ext_wdata=0x12345678; cpu_done at cycle 2; stall high cycles 0–1; cpu_rdata unchanged.
- Timeout with TIMEOUT=4:
  - Stimulus: read with no ack.
  - Response: ext_req high cycles 1–4; cpu_done=bus_err=1 at cycle 5; cpu_rdata=0.
- Internal access and stray ack:
  - Stimulus: cs=0, cpu_re=1, addr=0x0A04; ext_ack pulses while IDLE.
  - Response: stall=0, ext_req=0, no state change.
- Reset mid-operation:
  - Stimulus: rst_n low during REQ cycle 2.
  - Response: ext_req=0 and cpu_stall=0 asynchronously, state=IDLE; a fresh read after reset completes normally.
- Simultaneous re/we:
  - Stimulus: both asserted.
  - Response: ext_we=1 (write performed).
